uart_rx_byte: RTL and testbench

//   Serial-to-parallel UART receiver (8N1, LSB first).

---
 rtl/uart_rx_byte.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_byte.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, LSB first.
// Turns the raw serial line into whole bytes with a one-cycle valid strobe,
// flags framing errors and reports when a frame is in progress.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitidx_q, bitidx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  // Only the second synchroniser stage may feed the receive logic.
  assign rx_s = sync2_q;

  // Next-state and next-output computation for the receive state machine.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitidx_d    = bitidx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_s == 1'b0) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d    = '0;
          bitidx_d = 3'd0;
          if (rx_s == 1'b0) begin
            state_d = S_DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          // Right shift so the first received bit ends up in bit 0.
          shift_d = {rx_s, shift_q[7:1]};
          if (bitidx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitidx_d = bitidx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s == 1'b1) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            // Returning to IDLE at mid stop bit leaves half a bit to catch
            // a back-to-back start edge.
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BREAK: begin
        // Wait out a held-low line so it reports only one framing error.
        cnt_d = '0;
        if (rx_s == 1'b1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // All state, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitidx_q    <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= uart_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitidx_q    <= bitidx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: scoreboard bench for uart_rx_byte with 16 clk per bit.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int      CPB   = 16;
  localparam realtime TCLK  = 10.0;
  localparam realtime TBIT  = 160.0;

  logic       clk;
  logic       rst_n;
  logic       uart_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int         n_checks;
  int         n_errors;
  int         cyc;
  int         valid_cnt;
  int         err_cnt;
  int         last_valid_cyc;
  int         prev_valid_cyc;
  logic [7:0] exp_q [$];

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_in   (uart_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  // Free-running 100 MHz clock.
  always #(TCLK/2) clk = ~clk;

  // Cycle counter used for latency and spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every rx_valid, counts strobes.
  always @(negedge clk) begin
    if (rx_valid || frame_err)
      chk("valid_err_excl", {31'd0, rx_valid & frame_err}, 32'd0);
    if (rx_valid) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, e});
      end
    end
    if (frame_err) err_cnt++;
  end

  // Drive one frame; the expected byte is queued when the frame is a good one.
  task automatic send_byte(input logic [7:0] b, input logic stop_v,
                           input realtime bitp, input bit expect_rx);
    if (expect_rx) exp_q.push_back(b);
    uart_in = 1'b0;
    #(bitp);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      if (i == 4) begin
        #(bitp/2);
        if (expect_rx) chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        #(bitp/2);
      end else begin
        #(bitp);
      end
    end
    uart_in = stop_v;
    #(bitp);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st, v0, e0;
    logic saw_busy;
    n_checks = 0; n_errors = 0; cyc = 0;
    valid_cnt = 0; err_cnt = 0; last_valid_cyc = 0; prev_valid_cyc = 0;
    rst_n   = 1'b0;
    uart_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data",   {24'd0, rx_data}, 32'h00);
    chk("reset_rx_valid",  {31'd0, rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy",      {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) align();

    // 1: single byte, latency and busy fall at the stop midpoint.
    align();
    st = cyc;
    fork
      send_byte(8'h61, 1'b1, TBIT, 1'b1);
      begin
        repeat (150) @(posedge clk);
        #1 chk("t1_busy_before_stop_mid", {31'd0, busy}, 32'd1);
        repeat (8) @(posedge clk);
        #1 chk("t1_busy_after_stop_mid", {31'd0, busy}, 32'd0);
      end
    join
    repeat (5) align();
    chk("t1_valid_count", valid_cnt, 32'd1);
    chk("t1_rx_data_held", {24'd0, rx_data}, 32'h61);
    chk("t1_no_frame_err", err_cnt, 32'd0);
    chk("t1_latency_ok", {31'd0, ((last_valid_cyc - st) >= 154) && ((last_valid_cyc - st) <= 156)}, 32'd1);

    // 2: back-to-back frames with no idle gap.
    align();
    v0 = valid_cnt;
    send_byte(8'h73, 1'b1, TBIT, 1'b1);
    send_byte(8'h64, 1'b1, TBIT, 1'b1);
    repeat (5) align();
    chk("t2_valid_count", valid_cnt - v0, 32'd2);
    chk("t2_spacing", last_valid_cyc - prev_valid_cyc, 32'd160);
    chk("t2_rx_data", {24'd0, rx_data}, 32'h64);

    // 3: 4-clk low glitch is rejected.
    align();
    v0 = valid_cnt; e0 = err_cnt;
    uart_in = 1'b0;
    repeat (4) align();
    uart_in = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    chk("t3_busy_pulsed", {31'd0, saw_busy}, 32'd1);
    chk("t3_busy_returned", {31'd0, busy}, 32'd0);
    repeat (20) align();
    chk("t3_no_valid", valid_cnt - v0, 32'd0);
    chk("t3_no_frame_err", err_cnt - e0, 32'd0);

    // 4: good byte, then bad stop bit followed by a held-low line.
    align();
    send_byte(8'h7a, 1'b1, TBIT, 1'b1);
    repeat (5) align();
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h78, 1'b0, TBIT, 1'b0);
    repeat (40) align();
    chk("t4_one_frame_err", err_cnt - e0, 32'd1);
    chk("t4_no_valid", valid_cnt - v0, 32'd0);
    chk("t4_rx_data_kept", {24'd0, rx_data}, 32'h7a);
    chk("t4_busy_in_break", {31'd0, busy}, 32'd1);
    uart_in = 1'b1;
    repeat (6) align();
    chk("t4_busy_cleared", {31'd0, busy}, 32'd0);
    chk("t4_still_one_err", err_cnt - e0, 32'd1);

    // 5: reset during data bit 3, then a fresh frame.
    align();
    v0 = valid_cnt; e0 = err_cnt;
    fork
      send_byte(8'h63, 1'b1, TBIT, 1'b0);
      begin
        #(72*TCLK);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_rx_data",   {24'd0, rx_data}, 32'h00);
        chk("t5_reset_rx_valid",  {31'd0, rx_valid}, 32'd0);
        chk("t5_reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("t5_reset_busy",      {31'd0, busy}, 32'd0);
      end
    join
    repeat (10) align();
    rst_n = 1'b1;
    repeat (5) align();
    chk("t5_no_strobe", (valid_cnt - v0) + (err_cnt - e0), 32'd0);
    send_byte(8'h76, 1'b1, TBIT, 1'b1);
    repeat (5) align();
    chk("t5_one_valid", valid_cnt - v0, 32'd1);
    chk("t5_rx_data", {24'd0, rx_data}, 32'h76);

    // 6: random bytes with the sender's bit period off by about 3 percent.
    align();
    e0 = err_cnt;
    for (int n = 0; n < 256; n++) begin
      logic [7:0] b;
      realtime bp;
      b  = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 1) == 1) ? 165.0 : 155.0;
      send_byte(b, 1'b1, bp, 1'b1);
      #($urandom_range(0, 30));
    end
    repeat (20) align();
    chk("t6_no_frame_err", err_cnt - e0, 32'd0);

    chk("sb_empty", exp_q.size(), 32'd0);
    chk("total_valid", valid_cnt, 32'd261);
    chk("total_frame_err", err_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
